rrat_commit: RTL and testbench



---
 rtl/rrat_commit_if.sv | 24 ++
 rtl/rrat_commit.sv | 108 ++++++++++
 tb/tb_rrat_commit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/rrat_commit_if.sv
// Commit-side and free-list-side handshake bundle for the retirement RAT.
// The slave modport is the RRAT; the master modport is the ROB/free-list side.
interface rrat_commit_if #(
  parameter int SS   = 2,
  parameter int PR_W = 6
);
  logic [SS-1:0]           commit_valid;
  logic [SS-1:0][4:0]      commit_rd_arch;
  logic [SS-1:0][PR_W-1:0] commit_rd_phys;
  logic                    commit_ready;
  logic                    free_valid;
  logic [PR_W-1:0]         free_preg;
  logic                    free_ready;

  modport master (
    output commit_valid, commit_rd_arch, commit_rd_phys, free_ready,
    input  commit_ready, free_valid, free_preg
  );

  modport slave (
    input  commit_valid, commit_rd_arch, commit_rd_phys, free_ready,
    output commit_ready, free_valid, free_preg
  );
endinterface

// File: rtl/rrat_commit.sv
// Retirement RAT: records committed arch->phys mappings and queues displaced pregs for the free list.
// Optional RRAT_PERF_EN adds a 64-bit retired-instruction counter output (retired_count).
module rrat_commit #(
  parameter int SS          = 2,
  parameter int N_PHYS      = 64,
  parameter int FREEQ_DEPTH = 8
) (
  input logic          clk,
  input logic          rst,
  rrat_commit_if.slave rr
`ifdef RRAT_PERF_EN
  ,
  output logic [63:0]  retired_count
`endif
);
  localparam int PR_W  = $clog2(N_PHYS);
  localparam int PTR_W = $clog2(FREEQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FREEQ_DEPTH);
  localparam logic [CNT_W-1:0] SS_C    = CNT_W'(SS);

  logic [PR_W-1:0]  map_q  [32];
  logic [PR_W-1:0]  map_d  [32];
  logic [PR_W-1:0]  fifo_q [FREEQ_DEPTH];
  logic [PR_W-1:0]  fifo_d [FREEQ_DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] push_n;
  logic [CNT_W-1:0] free_space;
  logic             accept;
  logic             pop;

  // Readiness uses the registered count only, so a same-cycle pop never frees room early.
  assign free_space      = DEPTH_C - count_q;
  assign rr.commit_ready = (free_space >= SS_C);
  assign accept          = rr.commit_ready && rr.commit_valid[0];
  assign rr.free_valid   = (count_q != '0);
  assign rr.free_preg    = fifo_q[head_q];
  assign pop             = rr.free_valid && rr.free_ready;

  // Lanes are walked in order against the running map so a repeated rd sees the earlier lane's preg.
  always_comb begin
    map_d  = map_q;
    fifo_d = fifo_q;
    tail_d = tail_q;
    push_n = '0;
    if (accept) begin
      for (int i = 0; i < SS; i++) begin
        if (rr.commit_valid[i] && (rr.commit_rd_arch[i] != 5'd0)) begin
          fifo_d[tail_d]                 = map_d[rr.commit_rd_arch[i]];
          map_d[rr.commit_rd_arch[i]]    = rr.commit_rd_phys[i];
          tail_d                         = tail_d + PTR_W'(1);
          push_n                         = push_n + CNT_W'(1);
        end
      end
    end
    head_d  = head_q + PTR_W'(pop);
    count_d = count_q + push_n - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        map_q[i] <= PR_W'(i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      map_q   <= map_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entries beyond the count are don't-care, so the storage needs no reset.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

`ifdef RRAT_PERF_EN
  logic [63:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q;
    if (accept) begin
      for (int i = 0; i < SS; i++) begin
        if (rr.commit_valid[i]) begin
          retired_d = retired_d + 64'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_rrat_commit.sv
// Scoreboard bench for rrat_commit: a reference map/queue model predicts releases and readiness.
module tb_rrat_commit;
  localparam int SS     = 2;
  localparam int N_PHYS = 64;
  localparam int DEPTH  = 8;
  localparam int PR_W   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rrat_commit_if #(.SS(SS), .PR_W(PR_W)) bus ();

`ifdef RRAT_PERF_EN
  logic [63:0] retired_count;
`endif

  rrat_commit #(.SS(SS), .N_PHYS(N_PHYS), .FREEQ_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .rr  (bus)
`ifdef RRAT_PERF_EN
    ,
    .retired_count (retired_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: architectural map, expected release order, FIFO occupancy, retired total.
  int          ref_map [32];
  int          exp_q [$];
  int          occ;
  logic [63:0] perf_m;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_map[i] = i;
    exp_q.delete();
    occ    = 0;
    perf_m = '0;
  endtask

  task automatic drive(input logic [1:0] v, input int a0, input int p0,
                       input int a1, input int p1, input logic fr);
    bus.commit_valid      = v;
    bus.commit_rd_arch[0] = 5'(a0);
    bus.commit_rd_arch[1] = 5'(a1);
    bus.commit_rd_phys[0] = 6'(p0);
    bus.commit_rd_phys[1] = 6'(p1);
    bus.free_ready        = fr;
  endtask

  task automatic step(input logic [1:0] v, input int a0, input int p0,
                      input int a1, input int p1, input logic fr);
    int   a [2];
    int   p [2];
    logic rdy, acc, pop;
    drive(v, a0, p0, a1, p1, fr);
    a[0] = a0; a[1] = a1; p[0] = p0; p[1] = p1;
    @(negedge clk);
    rdy = ((DEPTH - occ) >= SS);
    pop = (occ != 0) && fr;
    acc = rdy && v[0];
    check("commit_ready", {63'd0, bus.commit_ready}, {63'd0, rdy});
    check("free_valid", {63'd0, bus.free_valid}, {63'd0, (occ != 0)});
`ifdef RRAT_PERF_EN
    check("retired_count", retired_count, perf_m);
`endif
    @(posedge clk);
    if (acc) begin
      for (int i = 0; i < SS; i++) begin
        if (v[i]) begin
          perf_m = perf_m + 64'd1;
          if (a[i] != 0) begin
            exp_q.push_back(ref_map[a[i]]);
            ref_map[a[i]] = p[i];
            occ++;
          end
        end
      end
    end
    if (pop) occ--;
    #1;
  endtask

  task automatic idle(input logic fr);
    step(2'b00, 0, 0, 0, 0, fr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b11, 9, 1, 10, 2, 1'b1);
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (occ == 0) break;
      idle(1'b1);
    end
    if (occ != 0) begin
      errors++;
      $display("FAIL drain timeout: model occupancy %0d, required 0", occ);
    end
  endtask

  task automatic random_run(input int n);
    logic [1:0] v;
    int         a0, a1;
    logic       fr;
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0:       v = 2'b00;
        1:       v = 2'b01;
        default: v = 2'b11;
      endcase
      a0 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      a1 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      fr = ($urandom_range(0, 3) != 0);
      step(v, a0, $urandom_range(0, N_PHYS - 1), a1, $urandom_range(0, N_PHYS - 1), fr);
    end
  endtask

  // Monitor: every DUT pop is matched against the oldest predicted release.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.free_valid === 1'b1 && bus.free_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL free_preg unexpected: got %0d, required no release pending", bus.free_preg);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (bus.free_preg !== 6'(e)) begin
          errors++;
          $display("FAIL free_preg order: got %0d, required %0d", bus.free_preg, e);
        end
      end
    end
  end

  initial begin
    model_reset();
    drive(2'b00, 0, 0, 0, 0, 1'b0);
    do_reset();

    // Single commit, release latency and map update (re-commit of rd 5 must release 40).
    step(2'b01, 5, 40, 0, 0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    step(2'b01, 5, 41, 0, 0, 1'b1);
    idle(1'b1);

    // Same rd twice in one group: releases 3 then 33, map ends at 34.
    step(2'b11, 3, 33, 3, 34, 1'b1);
    idle(1'b1);
    idle(1'b1);
    step(2'b01, 3, 35, 0, 0, 1'b1);
    idle(1'b1);

    // x0 lane produces no release and leaves map[0] alone.
    step(2'b11, 0, 50, 7, 51, 1'b1);
    idle(1'b1);
    step(2'b01, 0, 52, 0, 0, 1'b1);
    drain();

    // Back-pressure: fill to 8, reject a 5th group, then release two to reopen.
    step(2'b11, 10, 20, 11, 21, 1'b0);
    step(2'b11, 12, 22, 13, 23, 1'b0);
    step(2'b11, 14, 24, 15, 25, 1'b0);
    step(2'b11, 16, 26, 17, 27, 1'b0);
    step(2'b11, 10, 60, 11, 61, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    drain();
    step(2'b11, 10, 62, 11, 63, 1'b1);
    drain();

    // Push and pop in the same cycle.
    step(2'b01, 20, 1, 0, 0, 1'b1);
    step(2'b11, 21, 2, 22, 3, 1'b1);
    drain();

    random_run(400);

    // Reset in the middle of traffic, with a commit presented during reset.
    step(2'b11, 4, 44, 6, 46, 1'b0);
    do_reset();
    idle(1'b1);
    step(2'b11, 4, 45, 6, 47, 1'b1);
    random_run(200);

    drain();
    idle(1'b1);
    check("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
